// File: rtl/ones_pattern_gen.sv
// Streams every WIDTH-bit word of popcount k in ascending order, one word per accepted handshake.
// Latency: first word valid the cycle after start; one word per cycle while word_ready stays high.
// Backpressure: word, word_idx and word_last hold while word_valid is high and word_ready is low.
module ones_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] k,
    output logic             busy,
    output logic             err,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word,
    output logic             word_last,
    output logic [IDX_W-1:0] word_idx
);

    localparam int EXT_W = WIDTH + 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] k_q;

    logic [EXT_W-1:0] x_ext;
    logic [EXT_W-1:0] c_ext;
    logic [EXT_W-1:0] r_ext;
    logic [EXT_W-1:0] diff_ext;
    logic [CNT_W-1:0] c_log2;
    logic [WIDTH-1:0] word_nxt;
    logic             handshake;

    // Lowest k bits set: the smallest word with popcount k.
    function automatic logic [WIDTH-1:0] first_word(input logic [CNT_W-1:0] kk);
        logic [EXT_W-1:0] one_hot;
        one_hot = EXT_W'(1) << kk;
        return WIDTH'(one_hot - EXT_W'(1));
    endfunction

    // Highest k bits set: the largest word with popcount k.
    function automatic logic [WIDTH-1:0] last_word(input logic [CNT_W-1:0] kk);
        return first_word(kk) << (CNT_W'(WIDTH) - kk);
    endfunction

    // Gosper's hack with one spare bit so the carry out of r is not lost.
    assign x_ext    = {1'b0, word};
    assign c_ext    = x_ext & (~x_ext + EXT_W'(1));
    assign r_ext    = x_ext + c_ext;
    assign diff_ext = r_ext ^ x_ext;

    // c is one-hot, so log2(c) is a plain priority encode and no divider is needed.
    always_comb begin
        c_log2 = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (c_ext[i]) begin
                c_log2 = CNT_W'(i);
            end
        end
    end

    assign word_nxt  = WIDTH'((diff_ext >> 2) >> c_log2) | r_ext[WIDTH-1:0];
    assign handshake = word_valid & word_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k_q        <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
            word_valid <= 1'b0;
            word_last  <= 1'b0;
            word       <= '0;
            word_idx   <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (k > CNT_W'(WIDTH)) begin
                            err <= 1'b1;
                        end else begin
                            state      <= RUN;
                            k_q        <= k;
                            busy       <= 1'b1;
                            word_valid <= 1'b1;
                            word       <= first_word(k);
                            word_idx   <= '0;
                            word_last  <= (k == '0) || (k == CNT_W'(WIDTH));
                        end
                    end
                end
                RUN: begin
                    if (handshake) begin
                        if (word_last) begin
                            // word and word_idx keep the final values for the consumer.
                            state      <= IDLE;
                            busy       <= 1'b0;
                            word_valid <= 1'b0;
                            word_last  <= 1'b0;
                        end else begin
                            word      <= word_nxt;
                            word_idx  <= word_idx + IDX_W'(1);
                            word_last <= (word_nxt == last_word(k_q));
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Randomized bench for ones_pattern_gen: expected sequences come from enumerating all words by popcount.
module tb_ones_pattern_gen;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int IDX_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] k;
    logic             busy;
    logic             err;
    logic             word_valid;
    logic             word_ready;
    logic [WIDTH-1:0] word;
    logic             word_last;
    logic [IDX_W-1:0] word_idx;

    int vec_cnt = 0;
    int err_cnt = 0;

    ones_pattern_gen #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W),
        .IDX_W(IDX_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .k          (k),
        .busy       (busy),
        .err        (err),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word       (word),
        .word_last  (word_last),
        .word_idx   (word_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_valid"}, word_valid, 0);
        chk({tag, "_last"}, word_last, 0);
        chk({tag, "_word"}, word, 0);
        chk({tag, "_idx"}, word_idx, 0);
    endtask

    // random_mode: random ready and stray start pulses; stall_idx: hold ready low 3 cycles there;
    // abort_idx: assert rst when that index is presented.
    task automatic run_seq(input int kk, input int random_mode, input int stall_idx, input int abort_idx);
        int   exp_q[$];
        int   n;
        int   cycles;
        int   stall_cnt;
        int   len;
        logic hs;
        for (int v = 0; v < (1 << WIDTH); v++) begin
            if ($countones(v) == kk) exp_q.push_back(v);
        end
        len = exp_q.size();
        start      = 1'b1;
        k          = CNT_W'(kk);
        word_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("first_word_latency", word_valid, 1);
        n         = 0;
        cycles    = 0;
        stall_cnt = 0;
        while (n < len && cycles < 4000) begin
            if (!word_valid) begin
                chk("valid_dropped_early", word_valid, 1);
                break;
            end
            chk("word", word, exp_q[n]);
            chk("idx", word_idx, n);
            chk("last", word_last, (n == len - 1));
            chk("busy_run", busy, 1);
            chk("err_run", err, 0);
            chk("popcount", $countones(word), kk);
            if (n == abort_idx) begin
                start = 1'b0;
                rst   = 1'b1;
                tick();
                rst = 1'b0;
                chk_reset_vals("abort");
                return;
            end
            word_ready = (random_mode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (n == stall_idx && stall_cnt < 3) begin
                word_ready = 1'b0;
                stall_cnt++;
            end
            start = (random_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            k     = CNT_W'($urandom_range(0, 15));
            hs    = word_ready;
            tick();
            cycles++;
            if (hs) n++;
        end
        start = 1'b0;
        chk("seq_len", n, len);
        chk("done_busy", busy, 0);
        chk("done_valid", word_valid, 0);
        chk("done_last", word_last, 0);
        chk("done_word_hold", word, exp_q[len-1]);
        chk("done_idx_hold", word_idx, len - 1);
        if (random_mode == 0 && stall_idx < 0) chk("zero_bubble_cycles", cycles, len);
        if (stall_idx >= 0) chk("stall_cycles", stall_cnt, 3);
        tick();
        chk("idle_valid", word_valid, 0);
    endtask

    task automatic run_err(input int kk);
        start = 1'b1;
        k     = CNT_W'(kk);
        tick();
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_valid", word_valid, 0);
        chk("err_busy", busy, 0);
        tick();
        chk("err_clear", err, 0);
        chk("err_valid2", word_valid, 0);
        chk("err_busy2", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        k          = '0;
        word_ready = 1'b0;
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();
        chk_reset_vals("post_reset");

        run_seq(2, 0, -1, -1);
        run_seq(0, 0, -1, -1);
        run_seq(8, 0, -1, -1);
        run_seq(4, 0, -1, -1);
        run_err(9);
        run_err(15);
        run_seq(3, 0, 5, -1);
        run_seq(3, 1, -1, -1);
        run_seq(4, 0, -1, 10);
        run_seq(1, 0, -1, -1);
        repeat (6) begin
            run_seq($urandom_range(0, WIDTH), 1, -1, -1);
        end
        repeat (3) begin
            run_err($urandom_range(WIDTH + 1, 15));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
